// File: rtl/slice_reader.sv
// slice_reader
// Streams a full state image (2^ADDR_W slice words) out of a synchronous-read
// slice memory in ascending address order over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a transfer (sampled only while idle)
//   clear      synchronous abort back to idle (highest priority)
//   rd_en      memory read strobe, high exactly while fetching
//   rd_addr    memory read address (the internal slice counter)
//   rd_data    memory read data, valid the cycle after rd_en
//   out_data   registered output word, stable while out_valid is high
//   out_valid  output word available
//   out_ready  downstream accepts the word
//   out_last   current output word is the final slice
//   busy       a transfer is in progress
//   done       one-cycle pulse after the final word is accepted
module slice_reader #(
    parameter int unsigned DATA_W = 25,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StSend,
        StDone
    } state_t;

    localparam logic [ADDR_W-1:0] LastAddr = '1;
    localparam logic [ADDR_W-1:0] AddrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            // out_data deliberately keeps its last value on abort
            state     <= StIdle;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        rd_addr <= '0;
                        state   <= StFetch;
                    end
                end
                StFetch: begin
                    state <= StLatch;
                end
                StLatch: begin
                    // memory data for the fetched address is valid now
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    state     <= StSend;
                end
                StSend: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_addr == LastAddr) begin
                            // counter parks on the last address until next start
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            rd_addr <= rd_addr + AddrOne;
                            state   <= StFetch;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign rd_en    = (state == StFetch);
    assign busy     = (state != StIdle);
    assign out_last = out_valid && (rd_addr == LastAddr);

endmodule

// File: tb/tb_slice_reader.sv
module tb_slice_reader;
    localparam int DW = 25;
    localparam int AW = 6;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clear;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    slice_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read slice memory
    logic [DW-1:0] mem [N];
    always @(posedge clk) if (rd_en === 1'b1) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log: a handshake seen at a negedge completes at the next posedge
    logic [DW-1:0] got[$];
    bit            got_last[$];
    int            hs_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back(out_data);
            got_last.push_back(out_last === 1'b1);
            hs_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int base  = 0;
    int dbase = 0;

    function automatic logic [35:0] outs();
        return {rd_en, out_valid, out_last, busy, done, rd_addr, out_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        base  = got.size();
        dbase = done_cnt;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (out_valid === 1'b1 && got.size() - base == n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done_cnt - dbase > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        int s;
        bit ok;
        rst = 1'b1; start = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (outs() !== 36'd0) begin
            n_bad++; $display("FAIL reset_values got=%h want=0", outs());
        end
        rst = 1'b0;
        tick();
        fill_random();
        mark();
        pulse_start(s);
        wait_word(0, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL reset_prep_timeout got=0 want=1"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 36'd0) begin
            n_bad++; $display("FAIL async_reset got=%h want=0", outs());
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (outs() !== 36'd0) begin
                n_bad++; $display("FAIL idle_stable[%0d] got=%h want=0", i, outs());
            end
        end
    endtask

    task automatic test_full_transfer();
        int s;
        bit ok;
        for (int i = 0; i < N; i++) mem[i] = DW'(i * 3 + 1);
        out_ready = 1'b1;
        mark();
        pulse_start(s);
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL full_done_timeout got=0 want=1"); end
        n_cmp++;
        if (got.size() - base !== N) begin
            n_bad++; $display("FAIL full_count got=%0d want=%0d", got.size() - base, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (got[base+k] !== DW'(k * 3 + 1)) begin
                    n_bad++; $display("FAIL full_word[%0d] got=%0d want=%0d", k, got[base+k], k * 3 + 1);
                end
                n_cmp++;
                if (got_last[base+k] !== (k == N - 1)) begin
                    n_bad++; $display("FAIL full_last[%0d] got=%0d want=%0d", k, got_last[base+k], k == N - 1);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (hs_cyc[base+k] - hs_cyc[base+k-1] !== 3) begin
                        n_bad++; $display("FAIL full_spacing[%0d] got=%0d want=3", k, hs_cyc[base+k] - hs_cyc[base+k-1]);
                    end
                end
            end
            n_cmp++;
            if (hs_cyc[base] - s !== 3) begin
                n_bad++; $display("FAIL start_latency got=%0d want=3", hs_cyc[base] - s);
            end
            n_cmp++;
            if (hs_cyc[base+N-1] - s !== 192) begin
                n_bad++; $display("FAIL total_cycles got=%0d want=192", hs_cyc[base+N-1] - s);
            end
            n_cmp++;
            if (done_cyc - hs_cyc[base+N-1] !== 1) begin
                n_bad++; $display("FAIL done_delay got=%0d want=1", done_cyc - hs_cyc[base+N-1]);
            end
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL after_done_busy_done got=%b want=00", {busy, done});
        end
        n_cmp++;
        if (rd_addr !== AW'(N - 1)) begin
            n_bad++; $display("FAIL addr_parked got=%0d want=%0d", rd_addr, N - 1);
        end
        repeat (5) tick();
        n_cmp++;
        if (done_cnt - dbase !== 1) begin
            n_bad++; $display("FAIL full_done_count got=%0d want=1", done_cnt - dbase);
        end
    endtask

    task automatic test_backpressure();
        int s;
        bit ok;
        for (int i = 0; i < N; i++) mem[i] = DW'(i * 3 + 1);
        out_ready = 1'b1;
        mark();
        pulse_start(s);
        wait_word(10, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_reach_timeout got=0 want=1"); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, rd_en, out_data} !== {1'b1, 1'b0, DW'(31)}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got=v%b r%b d%0d want=v1 r0 d31", i, out_valid, rd_en, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
        n_cmp++;
        if (got.size() - base !== N) begin
            n_bad++; $display("FAIL bp_count got=%0d want=%0d", got.size() - base, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (got[base+k] !== DW'(k * 3 + 1)) begin
                    n_bad++; $display("FAIL bp_word[%0d] got=%0d want=%0d", k, got[base+k], k * 3 + 1);
                end
            end
            n_cmp++;
            if (hs_cyc[base+10] - hs_cyc[base+9] !== 8) begin
                n_bad++; $display("FAIL bp_stall_gap got=%0d want=8", hs_cyc[base+10] - hs_cyc[base+9]);
            end
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int s;
        int s2;
        bit ok;
        fill_random();
        out_ready = 1'b1;
        mark();
        pulse_start(s);
        wait_word(20, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL sb_reach_timeout got=0 want=1"); end
        pulse_start(s2);
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL sb_done_timeout got=0 want=1"); end
        n_cmp++;
        if (got.size() - base !== N) begin
            n_bad++; $display("FAIL sb_count got=%0d want=%0d", got.size() - base, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (got[base+k] !== mem[k]) begin
                    n_bad++; $display("FAIL sb_word[%0d] got=%h want=%h", k, got[base+k], mem[k]);
                end
            end
        end
        repeat (6) tick();
        n_cmp++;
        if ({busy, done_cnt - dbase} !== {1'b0, 32'sd1}) begin
            n_bad++; $display("FAIL sb_single_done got=busy%b done%0d want=busy0 done1", busy, done_cnt - dbase);
        end
    endtask

    task automatic test_clear();
        int s;
        bit ok;
        logic [DW-1:0] held;
        // start coinciding with clear in idle is ignored
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        n_cmp++;
        if ({busy, rd_en} !== 2'b00) begin
            n_bad++; $display("FAIL clear_start_ignored got=%b want=00", {busy, rd_en});
        end
        fill_random();
        out_ready = 1'b1;
        mark();
        pulse_start(s);
        wait_word(7, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL clr_reach_timeout got=0 want=1"); end
        out_ready = 1'b0;
        held = mem[7];
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if ({out_valid, busy, rd_en, rd_addr} !== {3'b000, AW'(0)}) begin
            n_bad++; $display("FAIL clr_idle got=v%b b%b e%b a%0d want=v0 b0 e0 a0", out_valid, busy, rd_en, rd_addr);
        end
        n_cmp++;
        if (out_data !== held) begin
            n_bad++; $display("FAIL clr_data_held got=%h want=%h", out_data, held);
        end
        out_ready = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if ({got.size() - base, done_cnt - dbase} !== {32'sd7, 32'sd0}) begin
            n_bad++; $display("FAIL clr_quiet got=words%0d done%0d want=words7 done0", got.size() - base, done_cnt - dbase);
        end
        fill_random();
        mark();
        pulse_start(s);
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL clr_restart_timeout got=0 want=1"); end
        n_cmp++;
        if (got.size() - base !== N) begin
            n_bad++; $display("FAIL clr_restart_count got=%0d want=%0d", got.size() - base, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (got[base+k] !== mem[k]) begin
                    n_bad++; $display("FAIL clr_restart_word[%0d] got=%h want=%h", k, got[base+k], mem[k]);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok;
        fill_random();
        out_ready = 1'b1;
        mark();
        pulse_start(s);
        wait_word(40, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL rm_reach_timeout got=0 want=1"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 36'd0) begin
            n_bad++; $display("FAIL rm_async_reset got=%h want=0", outs());
        end
        @(negedge clk) rst = 1'b0;
        tick();
        fill_random();
        mark();
        pulse_start(s);
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL rm_restart_timeout got=0 want=1"); end
        n_cmp++;
        if (got.size() - base !== N) begin
            n_bad++; $display("FAIL rm_restart_count got=%0d want=%0d", got.size() - base, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (got[base+k] !== mem[k]) begin
                    n_bad++; $display("FAIL rm_restart_word[%0d] got=%h want=%h", k, got[base+k], mem[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_backpressure();
        test_start_while_busy();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
